// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID pipeline stage: canonical NOP, payload bundle
// and the {main_v, skid_v} state encoding used by the skid buffer.
package ifid_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_RV32I = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_incr;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with a registered in_ready and a
// synchronous flush that empties both entries.
module pipe_skid_buf
  import ifid_pkg::*;
#(
  parameter int unsigned      WIDTH     = 96,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_v, skid_v, ready_q;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & ready_q & ~flush;
  assign out_xfer = main_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      ready_q   <= 1'b1;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (flush) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      ready_q   <= 1'b1;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      case ({main_v, skid_v})
        ST_EMPTY: begin
          if (in_xfer) begin
            main_v    <= 1'b1;
            main_data <= in_data;
          end
        end
        ST_FULL1: begin
          if (in_xfer && out_xfer) begin
            main_data <= in_data;
          end else if (in_xfer) begin
            // Decode stalled: park the newcomer behind main so order is kept.
            skid_v    <= 1'b1;
            skid_data <= in_data;
            ready_q   <= 1'b0;
          end else if (out_xfer) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL2: begin
          if (out_xfer) begin
            main_data <= skid_data;
            skid_v    <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          main_v  <= 1'b0;
          skid_v  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_v;
  assign out_data  = main_data;

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush and NOP bubbles.
// SKID_EN selects a 2-entry skid buffer (registered in_ready) or a single register.
module ifid_pipe_stage
  import ifid_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_RV32I),
  parameter bit              SKID_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_incr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_incr
);

  localparam int unsigned PW = 3 * XLEN;
  localparam logic [PW-1:0] EMPTY_PAYLOAD = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};

  logic          main_v;
  logic [PW-1:0] main_data;
  logic [PW-1:0] in_data;

  assign in_data = {in_instr, in_pc, in_pc_incr};

  if (SKID_EN) begin : g_skid
    pipe_skid_buf #(
      .WIDTH    (PW),
      .RESET_VAL(EMPTY_PAYLOAD)
    ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(main_v),
      .out_ready(out_ready),
      .out_data (main_data)
    );
  end else begin : g_reg
    logic in_xfer, out_xfer;

    // Combinational ready: a draining entry frees the slot in the same cycle.
    assign in_ready = ~main_v | out_ready;
    assign in_xfer  = in_valid & in_ready & ~flush;
    assign out_xfer = main_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_v    <= 1'b0;
        main_data <= EMPTY_PAYLOAD;
      end else if (flush) begin
        main_v    <= 1'b0;
        main_data <= EMPTY_PAYLOAD;
      end else if (in_xfer) begin
        main_v    <= 1'b1;
        main_data <= in_data;
      end else if (out_xfer) begin
        main_v <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid   = main_v;
    out_instr   = NOP_INSTR;
    out_pc      = '0;
    out_pc_incr = '0;
    if (main_v) begin
      out_instr   = main_data[PW-1 -: XLEN];
      out_pc      = main_data[2*XLEN-1 -: XLEN];
      out_pc_incr = main_data[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Self-checking bench: directed vector table and corner sequences, then a random
// soak of both SKID_EN builds against queue-based reference models.
module tb_ifid_pipe_stage;
  import ifid_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, in_pc_incr = '0;

  logic        rdy1, ov1, rdy0, ov0;
  logic [31:0] oi1, op1, opi1, oi0, op0, opi0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifid_pipe_stage #(.XLEN(32), .NOP_INSTR(NOP), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_incr(in_pc_incr), .out_valid(ov1),
    .out_ready(out_ready), .out_instr(oi1), .out_pc(op1), .out_pc_incr(opi1)
  );

  ifid_pipe_stage #(.XLEN(32), .NOP_INSTR(NOP), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_incr(in_pc_incr), .out_valid(ov0),
    .out_ready(out_ready), .out_instr(oi0), .out_pc(op0), .out_pc_incr(opi0)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] pc, input logic ordy);
    flush      = f;
    in_valid   = iv;
    in_pc      = pc;
    in_instr   = instr_of(pc);
    in_pc_incr = pc + 32'd4;
    out_ready  = ordy;
  endtask

  typedef struct {
    logic        f;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[13];

  typedef struct {
    logic        ov;
    logic [31:0] instr, pc, pc_incr;
    logic        rdy;
  } obs_t;

  task automatic chk_model(input string tag, input obs_t o, input payload_t q[$],
                           input logic e_rdy);
    payload_t h;
    h = q.size() > 0 ? q[0] : '{instr: NOP, pc: 32'd0, pc_incr: 32'd0};
    chk({tag, " out_valid"}, 32'(o.ov), 32'(q.size() > 0));
    chk({tag, " out_instr"}, o.instr, h.instr);
    chk({tag, " out_pc"}, o.pc, h.pc);
    chk({tag, " out_pc_incr"}, o.pc_incr, h.pc_incr);
    chk({tag, " in_ready"}, 32'(o.rdy), 32'(e_rdy));
  endtask

  initial begin
    payload_t q1[$], q0[$];
    payload_t p;
    logic     er1, er0, ix1, ix0;
    obs_t     o;

    //        flush iv  pc       ordy  ov  pc       rdy
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 1'b1, 32'h04, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 32'h08, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h10, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 32'h20, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h28, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};

    // Reset state
    #2;
    chk("rst out_valid", 32'(ov1), 32'd0);
    chk("rst out_instr", oi1, NOP);
    chk("rst out_pc", op1, 32'd0);
    chk("rst out_pc_incr", opi1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready skid", 32'(rdy1), 32'd1);
    chk("rst in_ready reg", 32'(rdy0), 32'd1);

    // Streaming, back-pressure and flush on the skid build
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].f, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(ov1), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d out_pc", i), op1, vecs[i].e_pc);
      chk($sformatf("vec%0d out_instr", i), oi1,
          vecs[i].e_ov ? instr_of(vecs[i].e_pc) : NOP);
      chk($sformatf("vec%0d out_pc_incr", i), opi1,
          vecs[i].e_ov ? vecs[i].e_pc + 32'd4 : 32'd0);
      chk($sformatf("vec%0d in_ready", i), 32'(rdy1), 32'(vecs[i].e_rdy));
    end

    // Asynchronous reset mid-cycle with the skid build full
    @(negedge clk); drive(1'b0, 1'b1, 32'h30, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 32'h34, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre-rst out_pc", op1, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(ov1), 32'd0);
    chk("midrst out_instr", oi1, NOP);
    chk("midrst out_pc", op1, 32'd0);
    chk("midrst reg out_valid", 32'(ov0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst in_ready", 32'(rdy1), 32'd1);

    // Single-register build: combinational ready follows out_ready
    @(negedge clk); drive(1'b0, 1'b1, 32'h40, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("reg out_pc", op0, 32'h40);
    chk("reg stall in_ready", 32'(rdy0), 32'd0);
    drive(1'b0, 1'b1, 32'h44, 1'b1);
    #1;
    chk("reg drain in_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1;
    chk("reg capture out_pc", op0, 32'h44);
    chk("reg capture out_valid", 32'(ov0), 32'd1);

    // Random soak against queue models
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      flush          = ($urandom_range(0, 99) < 4);
      in_valid       = ($urandom_range(0, 99) < 70);
      out_ready      = ($urandom_range(0, 99) < 60);
      in_pc          = $urandom & 32'hFFFF_FFFC;
      in_instr       = $urandom;
      in_pc_incr     = in_pc + 32'd4;
      #1;
      er1 = q1.size() < 2;
      er0 = (q0.size() == 0) || out_ready;
      o = '{ov1, oi1, op1, opi1, rdy1};
      chk_model($sformatf("soak%0d skid", c), o, q1, er1);
      o = '{ov0, oi0, op0, opi0, rdy0};
      chk_model($sformatf("soak%0d reg", c), o, q0, er0);
      @(posedge clk);
      p   = '{instr: in_instr, pc: in_pc, pc_incr: in_pc_incr};
      ix1 = in_valid & er1 & ~flush;
      ix0 = in_valid & er0 & ~flush;
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (ix1) q1.push_back(p);
        if (ix0) q0.push_back(p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_stage.md
Name: ifid_pipe_stage

Overview:
- Parametrised instruction-fetch → decode pipeline stage carrying instruction, PC and PC+4, with a valid/ready handshake on both sides.
- Supports back-pressure from decode, a flush (redirect) input, and NOP-bubble output when the stage is empty.
- Optional 2-entry skid buffer makes upstream ready a pure register output, which breaks the combinational ready path from decode back to fetch.
- Sits between the fetch unit and the decode/register-file stage; replaces the fixed, always-enabled IF/ID register.

Parameters:
- XLEN, 32, width of instr/pc/pc_incr payload fields.
- NOP_INSTR, 32'h00000013, instruction presented on out_instr when the stage holds no valid entry (addi x0,x0,0).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries (branch/jump/trap redirect)
- in_valid  in  1  fetch presents a valid entry
- in_ready  out  1  stage can accept an entry this cycle
- in_instr  in  XLEN  fetched instruction
- in_pc  in  XLEN  PC of in_instr
- in_pc_incr  in  XLEN  PC + 4
- out_valid  out  1  entry presented to decode is valid
- out_ready  in  1  decode accepts the entry this cycle
- out_instr  out  XLEN  held instruction; NOP_INSTR when out_valid=0
- out_pc  out  XLEN  held PC; 0 when out_valid=0
- out_pc_incr  out  XLEN  held PC+4; 0 when out_valid=0

Behaviour:
- Transfer rules:
  - Input transfer (in_xfer) = in_valid & in_ready & ~flush.
  - Output transfer (out_xfer) = out_valid & out_ready.
- Reset (async, rst_n=0):
  - main_v = 0, skid_v = 0; all data registers reset to NOP_INSTR / 0 / 0.
  - Outputs during and after reset: out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_incr=0.
  - in_ready=1 after reset (SKID_EN=1: registered 1; SKID_EN=0: ~main_v).
- Output mux: out_* = main data when main_v, else NOP_INSTR/0/0. out_valid = main_v.
- Latency: one cycle, input to output, when the stage is empty or draining.
- SKID_EN=1, states by {main_v, skid_v}:
  - EMPTY(0,0):
    - in_xfer → FULL1, main loaded.
  - FULL1(1,0):
    - in_xfer & out_xfer → FULL1, main reloaded.
    - in_xfer & ~out_xfer → FULL2, input goes to skid; main unchanged.
    - ~in_xfer & out_xfer → EMPTY.
    - Otherwise hold.
  - FULL2(1,1):
    - in_ready=0, so no in_xfer is possible.
    - out_xfer → FULL1, skid moves to main.
    - Otherwise hold.
  - in_ready register: next = ~(next skid_v). It is 1 in EMPTY and FULL1, 0 in FULL2.
- SKID_EN=0:
  - in_ready = ~main_v | out_ready (combinational).
  - main loaded on in_xfer, cleared on out_xfer without in_xfer.
  - Skid logic must not be generated.
- Order preservation: entries leave in arrival order; skid data is never overtaken by newer input.
- Flush:
  - Any cycle flush=1 → next state EMPTY.
  - Data registers load NOP_INSTR/0/0; in_ready next = 1.
  - Same-cycle in_valid is dropped, not captured.
  - A same-cycle out_xfer still completes; decode sees the handshake, and flush ordering relative to it is the controller's concern.
- Simultaneous flush & reset: reset dominates.
- Stall: out_ready=0 with out_valid=1 holds all out_* stable until out_xfer or flush.
- Payload registers update only on load; no enable-less capture.

Decomposition:
- Shared package ifid_pkg holds:
  - the NOP_INSTR constant (RV32I canonical NOP);
  - a typedef for the payload bundle {instr, pc, pc_incr} of width 3*XLEN;
  - state encodings ST_EMPTY, ST_FULL1, ST_FULL2.
- One natural sub-module: pipe_skid_buf, a generic valid/ready 2-entry skid buffer over an opaque WIDTH-bit payload. ifid_pipe_stage instantiates it (SKID_EN=1) and adds flush, NOP-substitution and the output mux.

Test Plan:
1. Reset: hold rst_n=0 mid-run with entries held → immediately out_valid=0, out_instr=32'h00000013, out_pc=0; after release, in_ready=1.
2. Streaming: out_ready=1, in_valid=1 with pc 0x0,0x4,0x8 → out_pc 0x0,0x4,0x8 on consecutive cycles, one-cycle latency, in_ready stays 1.
3. Back-pressure (SKID_EN=1): load pc 0x10, drop out_ready, present pc 0x14 → in_ready=0 next cycle, out_pc holds 0x10. Raise out_ready → 0x10 then 0x14 emerge in order, and in_ready returns to 1 one cycle after the skid drains.
4. Flush while FULL2 (entries 0x20, 0x24) with in_valid=1 pc 0x28 → next cycle out_valid=0, out_instr=NOP, in_ready=1; 0x20/0x24/0x28 never appear at the output.
5. SKID_EN=0 build: out_valid=1, out_ready=0 → in_ready=0 the same cycle. out_ready=1 → in_ready=1 the same cycle, and the new entry is captured that edge.
6. Random valid/ready/flush soak (10k cycles, both SKID_EN) against a scoreboard queue model → no loss, no duplication, no reordering, out_* stable while stalled.
